mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single memory bus port between the instruction-fetch requester (I-side, stage_if) and the data requester (D-side, stage_mem). It handles one transaction at a time with a three-state FSM. The data side has fixed priority, with optional starvation protection for fetch. It also discards fetch responses made stale by a control-transfer flush. It sits between the pipeline stages and the memory/bus interface.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; DATA_W/8 byte strobes
- FAIR_LIMIT, 4, max consecutive D-side grants while I-side waits (used only with fairness compiled in)

Reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_abort  in  1  flush pulse; kills an outstanding fetch
- i_gnt  out  1  fetch accepted by bus
- i_rvalid  out  1  fetch data valid, one-cycle pulse
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte strobes
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data / store ack, one-cycle pulse
- d_rdata  out  DATA_W  load data
- m_req  out  1  bus request
- m_we  out  1  bus write enable
- m_addr  out  ADDR_W  bus address
- m_wdata  out  DATA_W  bus write data
- m_wstrb  out  DATA_W/8  bus strobes
- m_ready  in  1  bus accepts request when m_req && m_ready
- m_rvalid  in  1  bus response valid (loads and stores)
- m_rdata  in  DATA_W  bus response data

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE:** if any request is pending, pick the owner, latch its fields into the bus registers, and go to REQ. With no request, stay in IDLE.
- **Pick rule:** D-side wins over I-side.
- **Abort in IDLE:** an I-side request in the same cycle as i_abort is ignored.
- **REQ:** m_req = 1, driven from the latched fields.
  - When m_ready is high, pulse the owner's gnt and go to RESP.
  - If the owner is I-side and i_abort is high with m_ready low, drop m_req and return to IDLE. Bus withdrawal before acceptance is legal.
  - If i_abort and m_ready are high together, the transaction is accepted: go to RESP with drop = 1.
- **RESP:** new requests are not sampled.
  - When m_rvalid is high, route m_rdata to the owner and pulse its rvalid, unless drop is set. Then clear drop and go to IDLE.
  - i_abort while the owner is I-side sets drop.
  - A drop set in the m_rvalid cycle itself also suppresses i_rvalid.
- Store responses pulse d_rvalid; d_rdata is don't-care for stores.
- i_rdata and d_rdata are combinational copies of m_rdata.
- Abort affects only I-side transactions; it is ignored when the owner is D-side.
- **Reset** (mid-transaction included):
  - FSM returns to IDLE; all outputs, the latched fields, drop and the fairness counter clear to 0.
  - In-flight bus responses arriving after reset are ignored in IDLE.

## Timing
- Request sampled in cycle 0 (IDLE) → m_req in cycle 1.
- gnt in the first cycle with m_req && m_ready.
- rvalid in the same cycle as m_rvalid.
- Minimum request-to-data latency: 2 cycles (m_ready in cycle 1, m_rvalid in cycle 2).
- The FSM always passes through IDLE between transactions; maximum throughput is one transaction per 3 cycles.
- At most one gnt and at most one rvalid are asserted per cycle.

## Configuration
- ARB_FAIR_EN defined:
  - A counter (width $clog2(FAIR_LIMIT+1)) increments on each D-side pick made while i_req is also high.
  - The counter clears on an I-side pick, or on a D-side pick with i_req low.
  - When the counter equals FAIR_LIMIT and both requests are high, I-side wins.
- ARB_FAIR_EN undefined: strict D-side priority; counter logic absent.

## Structure
- Shared package / def_common.vh holds:
  - arb_state_e {IDLE, REQ, RESP}
  - arb_owner_e {OWN_I, OWN_D}
  - bus request struct (addr, we, wdata, wstrb)
- One sub-module, arb_pick: combinational owner selection plus the fairness counter register.
- FSM and bus registers live in the top module.

## Test plan
- **Single fetch:** i_req with i_addr = 0x1000; m_ready = 1 in cycle 1; m_rvalid in cycle 2 with m_rdata = 0x13 → i_gnt in cycle 1, i_rvalid with i_rdata = 0x13 in cycle 2, m_addr = 0x1000.
- **Simultaneous requests:** i_req and d_req in the same cycle, d_we = 1, d_wstrb = 0x0F → D-side served first (m_we = 1, d_rvalid pulse); I-side served next, with m_req 3 cycles after the first.
- **Abort before acceptance:** i_abort in REQ with m_ready = 0 → m_req drops next cycle, FSM in IDLE, no i_gnt.
- **Abort after acceptance:** i_abort in RESP, then m_rvalid → no i_rvalid; next d_req is served normally.
- **Starvation (ARB_FAIR_EN, FAIR_LIMIT = 4):** d_req and i_req held high continuously → D-side wins 4 grants, the 5th grant goes to I-side. Without the macro, I-side never wins.
- **Reset in RESP:** after reset, m_rvalid is ignored, all outputs are 0, and the next i_req is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types for the memory bus arbiter
package mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// rtl/mem_bus_arbiter_pick.sv - arb_pick owner selection; ARB_FAIR_EN adds the starvation counter
module arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pick_en,
  input  logic       i_req,
  input  logic       d_req,
  output logic       pick_valid,
  output arb_owner_e pick_owner
);

  assign pick_valid = i_req | d_req;

`ifdef ARB_FAIR_EN
  localparam int CNT_W = $clog2(FAIR_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             i_turn;

  // fetch has waited through FAIR_LIMIT data grants: it takes this slot
  assign i_turn     = i_req && d_req && (cnt_q == CNT_W'(FAIR_LIMIT));
  assign pick_owner = (d_req && !i_turn) ? OWN_D : OWN_I;

  // count consecutive data wins that left a fetch waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pick_en) begin
      if (pick_owner == OWN_D && i_req) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end
`else
  logic unused_pick;

  assign pick_owner  = d_req ? OWN_D : OWN_I;
  assign unused_pick = &{1'b0, clk, rst, pick_en, (FAIR_LIMIT != 0)};
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D memory bus arbiter, one transaction at a time; ARB_FAIR_EN enables fetch fairness
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_abort,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  bus_req_t   bus_q, bus_d;
  logic       drop_q, drop_d;

  logic       i_eff;
  logic       pick_en;
  logic       pick_valid;
  arb_owner_e pick_owner;
  logic       own_i;
  logic       kill;

  // a fetch raised together with a flush is already stale
  assign i_eff = i_req & ~i_abort;
  assign own_i = (owner_q == OWN_I);
  assign kill  = own_i & i_abort;

  arb_pick #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .pick_en    (pick_en),
    .i_req      (i_eff),
    .d_req      (d_req),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  assign m_we    = bus_q.we;
  assign m_addr  = bus_q.addr[ADDR_W-1:0];
  assign m_wdata = bus_q.wdata[DATA_W-1:0];
  assign m_wstrb = bus_q.wstrb[DATA_W/8-1:0];
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // state, owner, latched bus fields and the stale-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      bus_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bus_q   <= bus_d;
      drop_q  <= drop_d;
    end
  end

  // next state, bus latch, handshakes and response routing
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    bus_d    = bus_q;
    drop_d   = drop_q;
    pick_en  = 1'b0;
    m_req    = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          pick_en = 1'b1;
          owner_d = pick_owner;
          drop_d  = 1'b0;
          state_d = REQ;
          if (pick_owner == OWN_D) begin
            bus_d.addr  = ARB_ADDR_W'(d_addr);
            bus_d.we    = d_we;
            bus_d.wdata = ARB_DATA_W'(d_wdata);
            bus_d.wstrb = ARB_STRB_W'(d_wstrb);
          end else begin
            bus_d.addr  = ARB_ADDR_W'(i_addr);
            bus_d.we    = 1'b0;
            bus_d.wdata = '0;
            bus_d.wstrb = '0;
          end
        end
      end
      REQ: begin
        m_req = 1'b1;
        if (m_ready) begin
          i_gnt   = own_i;
          d_gnt   = ~own_i;
          drop_d  = kill;
          state_d = RESP;
        end else if (kill) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (m_rvalid) begin
          i_rvalid = own_i & ~drop_q & ~kill;
          d_rvalid = ~own_i;
          drop_d   = 1'b0;
          state_d  = IDLE;
        end else if (kill) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
